// File: rtl/fifo_drain_pkg.sv
// Shared types and widths for the transmit FIFO drain controller.
package fifo_drain_pkg;

    // Width of the inter-byte gap down-counter (GAP_CYCLES range 0..255).
    localparam int GAP_CNT_W  = 8;

    // Width of the optional started-byte counter.
    localparam int BYTE_CNT_W = 16;

    // Controller states, one byte transfer per pass from IDLE back to IDLE.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        POP       = 3'd1,
        LATCH     = 3'd2,
        START     = 3'd3,
        WAIT_BUSY = 3'd4,
        WAIT_DONE = 3'd5,
        GAP       = 3'd6
    } drain_state_t;

endpackage

// File: rtl/fifo_tx_drain_ctrl.sv
// Drain controller: sole reader of the transmit byte FIFO. Pops one byte,
// hands it to the UART transmitter with a start pulse, waits for the
// transmitter to finish, then idles for GAP_CYCLES before the next byte.
// Optional feature macro: FIFO_DRAIN_CNT_EN adds the byte_cnt port and a
// 16-bit wrapping count of started bytes.
module fifo_tx_drain_ctrl
    import fifo_drain_pkg::*;
#(
    parameter int GAP_CYCLES = 0,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    output logic              idle
`ifdef FIFO_DRAIN_CNT_EN
    ,
    output logic [BYTE_CNT_W-1:0] byte_cnt
`endif
);

    // Value loaded into the gap counter on entry to GAP; the counter then
    // spends exactly GAP_CYCLES cycles in GAP (GAP_CYCLES-1 down to 0).
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD =
        (GAP_CYCLES > 0) ? GAP_CNT_W'(GAP_CYCLES - 1) : '0;

    drain_state_t          state_q;
    logic [GAP_CNT_W-1:0]  gap_cnt_q;
    logic [DATA_W-1:0]     tx_data_q;
    logic                  rd_en_q;
    logic                  start_q;
    logic                  idle_q;

    // FSM with registered Moore outputs: rd_en_q, start_q and idle_q are
    // loaded together with the state they belong to, so each one is high
    // exactly while state_q is POP, START or IDLE respectively.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            gap_cnt_q <= '0;
            tx_data_q <= '0;
            rd_en_q   <= 1'b0;
            start_q   <= 1'b0;
            idle_q    <= 1'b1;
        end else begin
            rd_en_q <= 1'b0;
            start_q <= 1'b0;
            idle_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (en && !fifo_empty) begin
                        state_q <= POP;
                        rd_en_q <= 1'b1;
                    end else begin
                        idle_q <= 1'b1;
                    end
                end
                // Sole reader: the FIFO cannot drain between the IDLE check
                // and the read, so fifo_empty is not looked at again here.
                POP: begin
                    state_q <= LATCH;
                end
                LATCH: begin
                    tx_data_q <= fifo_data;
                    state_q   <= START;
                    start_q   <= 1'b1;
                end
                START: begin
                    state_q <= WAIT_BUSY;
                end
                // No timeout: a transmitter that never raises busy parks us here.
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_q <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (GAP_CYCLES > 0) begin
                            state_q   <= GAP;
                            gap_cnt_q <= GAP_LOAD;
                        end else begin
                            state_q <= IDLE;
                            idle_q  <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_q <= IDLE;
                        idle_q  <= 1'b1;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    idle_q  <= 1'b1;
                end
            endcase
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign tx_start   = start_q;
    assign tx_data    = tx_data_q;
    assign idle       = idle_q;

`ifdef FIFO_DRAIN_CNT_EN
    logic [BYTE_CNT_W-1:0] byte_cnt_q;
    logic [BYTE_CNT_W-1:0] byte_cnt_d;

    // Count each byte as it is started; wraps naturally at 16 bits.
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        if (state_q == START) begin
            byte_cnt_d = byte_cnt_q + 1'b1;
        end
    end

    // Started-byte counter register, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt_q <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign byte_cnt = byte_cnt_q;
`endif

endmodule
